// File: rtl/irq_pkg.sv
// Shared types and helpers for the programmable interrupt controller:
// FSM states, register offsets and the fixed-priority encoder function.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EOI  = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  // Lowest set bit wins: scanning downward lets the last hit be the lowest index.
  function automatic prio_t prio_enc(input logic [7:0] req);
    prio_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// Combinational fixed-priority encoder (bit 0 highest), WIDTH up to 8.
// Returns the winning index and whether any request is present.
module irq_prio_encoder
  import irq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [2:0]       idx_o,
  output logic             valid_o
);

  logic [7:0] req_ext;
  prio_t      enc;

  assign req_ext = 8'(req_i);
  assign enc     = prio_enc(req_ext);
  assign idx_o   = enc.idx;
  assign valid_o = enc.valid;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-captured pending bits, mask,
// fixed-priority arbitration, vectored intack, per-device ack and EOI.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ      = 8,
  parameter logic [11:0] BASE_ADDR    = 12'h0f8,
  parameter logic [15:0] SPURIOUS_VEC = 16'h000f
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [11:0]        address,
  input  logic [15:0]        data_out,
  input  logic               memwt,
  input  logic               intack,
  output logic               INT,
  output logic [15:0]        rd_data,
  output logic               rd_sel,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  irq_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic [11:0]        offset;
  logic               in_win;
  logic [1:0]         reg_sel;
  logic               wr_en;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_oh;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [2:0]         win_idx;
  logic               win_valid;
  logic               accept;
  logic               unused_data;

  // Wrapping subtraction makes any address below the base land far outside.
  assign offset   = address - BASE_ADDR;
  assign in_win   = (offset[11:2] == 10'd0);
  assign reg_sel  = offset[1:0];
  assign wr_en    = memwt & in_win;
  assign irq_edge = irq_i & ~irq_prev_q;
  assign eligible = pend_q & ~mask_q;

  irq_prio_encoder #(.WIDTH(NUM_IRQ)) u_enc (
    .req_i   (eligible),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win_oh      = NUM_IRQ'(1) << win_idx;
  assign accept      = (state_q == REQ) & win_valid & intack;
  assign unused_data = ^data_out[15:NUM_IRQ];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    isr_d    = isr_q;
    pend_clr = '0;
    if (wr_en && reg_sel == REG_PEND) pend_clr = data_out[NUM_IRQ-1:0];
    if (accept)                       pend_clr = pend_clr | win_oh;
    // A new edge always survives a same-cycle clear.
    pend_d = (pend_q & ~pend_clr) | irq_edge;
    mask_d = (wr_en && reg_sel == REG_MASK) ? data_out[NUM_IRQ-1:0] : mask_q;
    ack_d  = accept ? win_oh : '0;

    unique case (state_q)
      IDLE: if (win_valid) state_d = REQ;
      REQ: begin
        if (!win_valid) begin
          state_d = IDLE;
        end else if (intack) begin
          state_d = SERVICE;
          isr_d   = win_oh;
        end
      end
      SERVICE: begin
        if (wr_en && reg_sel == REG_EOI) begin
          state_d = IDLE;
          isr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= '1;
      isr_q      <= '0;
      irq_prev_q <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      isr_q      <= isr_d;
      irq_prev_q <= irq_i;
      ack_q      <= ack_d;
    end
  end

  // Gated by the live eligible set so a mask or clear drops INT right away.
  assign INT       = (state_q == REQ) & win_valid;
  assign irq_ack_o = ack_q;
  assign rd_sel    = intack | in_win;

  always_comb begin
    rd_data = '0;
    if (intack) begin
      rd_data = accept ? {13'd0, win_idx} : SPURIOUS_VEC;
    end else if (in_win) begin
      unique case (reg_sel)
        REG_PEND: rd_data = 16'(pend_q);
        REG_MASK: rd_data = 16'(mask_q);
        REG_ISR:  rd_data = 16'(isr_q);
        default:  rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller; every cycle is compared
// against a transaction-level reference model of pending/mask/service rules.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_i;
  logic [11:0] address;
  logic [15:0] data_out;
  logic        memwt;
  logic        intack;
  logic        INT;
  logic [15:0] rd_data;
  logic        rd_sel;
  logic [7:0]  irq_ack_o;

  int vectors     = 0;
  int miscompares = 0;

  irq_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq_i),
    .address   (address),
    .data_out  (data_out),
    .memwt     (memwt),
    .intack    (intack),
    .INT       (INT),
    .rd_data   (rd_data),
    .rd_sel    (rd_sel),
    .irq_ack_o (irq_ack_o)
  );

  always #5 clk = ~clk;

  // Reference model: sets of pending/masked lines, the line in service (-1 none),
  // whether the controller is currently presenting a request, and the ack owed.
  bit [7:0] m_pend, m_mask, m_prev;
  int       m_isr;
  bit       m_raised;
  int       m_ack;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_win();
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit m_int();
    return m_raised && (m_win() >= 0);
  endfunction

  function automatic bit m_in_win(logic [11:0] a);
    return (a >= 12'h0f8) && (a <= 12'h0fb);
  endfunction

  function automatic logic [15:0] m_rd();
    if (intack) return m_int() ? 16'(m_win()) : 16'h000f;
    if (!m_in_win(address)) return 16'h0000;
    case (address)
      12'h0f8: return {8'h00, m_pend};
      12'h0f9: return {8'h00, m_mask};
      12'h0fb: return (m_isr >= 0) ? 16'(1 << m_isr) : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = 8'hff; m_prev = '0;
    m_isr = -1; m_raised = 1'b0; m_ack = -1;
  endtask

  task automatic model_edge();
    int       w;
    bit       acc, wr;
    bit [7:0] clr;
    w   = m_win();
    acc = intack && m_int();
    wr  = memwt && m_in_win(address);
    clr = '0;
    if (wr && address == 12'h0f8) clr = data_out[7:0];
    if (acc) clr[w] = 1'b1;
    m_pend = (m_pend & ~clr) | (irq_i & ~m_prev);
    if (wr && address == 12'h0f9) m_mask = data_out[7:0];
    m_ack = acc ? w : -1;
    if (acc) begin
      m_isr    = w;
      m_raised = 1'b0;
    end else if (m_isr >= 0) begin
      if (wr && address == 12'h0fa) m_isr = -1;
    end else begin
      m_raised = (w >= 0);
    end
    m_prev = irq_i;
  endtask

  task automatic bus(logic [11:0] a, logic [15:0] d, logic wt, logic ack);
    address = a; data_out = d; memwt = wt; intack = ack;
  endtask

  task automatic idle();
    bus(12'h000, 16'h0000, 1'b0, 1'b0);
  endtask

  // One clock: compare all outputs mid-cycle, then advance model with the DUT.
  task automatic cycle();
    @(negedge clk);
    check("int", 16'(INT), 16'(m_int()));
    check("rd_sel", 16'(rd_sel), 16'(intack || m_in_win(address)));
    check("rd_data", rd_data, m_rd());
    check("irq_ack", 16'(irq_ack_o), (m_ack >= 0) ? 16'(1 << m_ack) : 16'h0000);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(string tag, logic [15:0] obs_sel, logic [15:0] exp);
    check(tag, obs_sel, exp);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    irq_i = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    address = 12'h0f9; #1;
    peek("rst_mask", rd_data, 16'h00ff);
    peek("rst_int", 16'(INT), 16'h0000);
    peek("rst_ack", 16'(irq_ack_o), 16'h0000);
    address = 12'h0f8; #1;
    peek("rst_pend", rd_data, 16'h0000);
    address = 12'h0fb; #1;
    peek("rst_isr", rd_data, 16'h0000);
    idle();
    release_reset();

    // 1: single line through the full request/ack/service path
    bus(12'h0f9, 16'h00fe, 1'b1, 1'b0); cycle();
    idle(); irq_i = 8'h01; cycle();
    irq_i = 8'h00; address = 12'h0f8; #1;
    peek("t1_pend", rd_data, 16'h0001);
    peek("t1_int_lo", 16'(INT), 16'h0000);
    cycle();
    idle(); #1;
    peek("t1_int_hi", 16'(INT), 16'h0001);
    intack = 1'b1; #1;
    peek("t1_vec", rd_data, 16'h0000);
    cycle();
    intack = 1'b0; address = 12'h0fb; #1;
    peek("t1_ack", 16'(irq_ack_o), 16'h0001);
    peek("t1_isr", rd_data, 16'h0001);
    cycle();
    peek("t1_ack_end", 16'(irq_ack_o), 16'h0000);
    bus(12'h0fa, 16'h0000, 1'b1, 1'b0); cycle();

    // 2: simultaneous edges, priority order, EOI re-arm latency
    bus(12'h0f9, 16'h0000, 1'b1, 1'b0); cycle();
    idle(); irq_i = 8'h24; cycle();
    irq_i = 8'h00; cycle();
    intack = 1'b1; #1;
    peek("t2_vec_a", rd_data, 16'h0002);
    cycle();
    bus(12'h0fa, 16'h1234, 1'b1, 1'b0); cycle();
    idle(); #1;
    peek("t2_int_gap", 16'(INT), 16'h0000);
    cycle();
    peek("t2_int_rearm", 16'(INT), 16'h0001);
    intack = 1'b1; #1;
    peek("t2_vec_b", rd_data, 16'h0005);
    cycle();
    bus(12'h0fa, 16'h0000, 1'b1, 1'b0); cycle();

    // 3: masked edge stays pending until unmasked
    bus(12'h0f9, 16'h0008, 1'b1, 1'b0); cycle();
    idle(); irq_i = 8'h08; cycle();
    irq_i = 8'h00; cycle(); cycle();
    address = 12'h0f8; #1;
    peek("t3_pend", rd_data, 16'h0008);
    peek("t3_int_lo", 16'(INT), 16'h0000);
    bus(12'h0f9, 16'h0000, 1'b1, 1'b0); cycle();
    idle(); cycle();
    peek("t3_int_hi", 16'(INT), 16'h0001);
    intack = 1'b1; cycle();
    bus(12'h0fa, 16'h0000, 1'b1, 1'b0); cycle();

    // 4: request withdrawn by W1C, then a spurious intack
    idle(); irq_i = 8'h02; cycle();
    irq_i = 8'h00; cycle();
    peek("t4_int_hi", 16'(INT), 16'h0001);
    bus(12'h0f8, 16'h0002, 1'b1, 1'b0); cycle();
    idle(); #1;
    peek("t4_int_lo", 16'(INT), 16'h0000);
    intack = 1'b1; #1;
    peek("t4_spur", rd_data, 16'h000f);
    cycle();
    intack = 1'b0; #1;
    peek("t4_no_ack", 16'(irq_ack_o), 16'h0000);
    cycle();

    // 5: edge beats a same-cycle W1C
    irq_i = 8'h10; bus(12'h0f8, 16'h0010, 1'b1, 1'b0); cycle();
    irq_i = 8'h00; bus(12'h0f8, 16'h0000, 1'b0, 1'b0); #1;
    peek("t5_pend", rd_data, 16'h0010);

    // 6: asynchronous reset while in service with a pending line
    cycle();
    idle(); intack = 1'b1; cycle();
    idle(); irq_i = 8'h10; cycle();
    irq_i = 8'h00; cycle();
    address = 12'h0f8; #1;
    peek("t6_pend_pre", rd_data, 16'h0010);
    address = 12'h0fb; #1;
    peek("t6_isr_pre", rd_data, 16'h0010);
    #1 rst_n = 1'b0; model_reset();
    #1;
    peek("t6_int", 16'(INT), 16'h0000);
    peek("t6_isr", rd_data, 16'h0000);
    address = 12'h0f8; #1;
    peek("t6_pend", rd_data, 16'h0000);
    address = 12'h0f9; #1;
    peek("t6_mask", rd_data, 16'h00ff);
    idle();
    release_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int op;
      if ($urandom_range(0, 2) == 0) irq_i = irq_i ^ (8'($urandom) & 8'($urandom));
      op = $urandom_range(0, 9);
      case (op)
        0, 1:    bus(12'h0f8 + 12'($urandom_range(0, 1)), 16'($urandom) & 16'($urandom), 1'b1, 1'b0);
        2:       bus(12'h0fa, 16'($urandom), 1'b1, 1'b0);
        3, 4:    bus(12'h0f8 + 12'($urandom_range(0, 3)), 16'h0000, 1'b0, 1'b1);
        5:       bus(12'h0f8 + 12'($urandom_range(0, 3)), 16'h0000, 1'b0, 1'b0);
        6:       bus(12'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        default: idle();
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
